// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the single-cycle core run controller.
//   run_state_t    : run sequencer states (IDLE, LAUNCH, RUN, DONE)
//   END_PC_DEFAULT : default PC value that marks normal program completion
//   CYC_W_DEFAULT  : default width of the run cycle counter
// ---------------------------------------------------------------------------
package core_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } run_state_t;

   localparam int END_PC_DEFAULT = 128;
   localparam int CYC_W_DEFAULT  = 16;

endpackage

// File: rtl/core_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// core_run_ctrl_if
// Host loader/readback port of the data memory.
//   host_req    : host memory access request            (host -> ctrl)
//   host_we     : host write (1) / read (0)             (host -> ctrl)
//   host_addr   : host address, 8 bits                  (host -> ctrl)
//   host_wdata  : host write data, 8 bits               (host -> ctrl)
//   host_gnt    : access accepted this cycle            (ctrl -> host)
//   host_rvalid : read data valid                       (ctrl -> host)
//   host_rdata  : registered read data, 8 bits          (ctrl -> host)
// Modports: master = host side, slave = run controller side.
// ---------------------------------------------------------------------------
interface core_run_ctrl_if;

   logic       host_req;
   logic       host_we;
   logic [7:0] host_addr;
   logic [7:0] host_wdata;
   logic       host_gnt;
   logic       host_rvalid;
   logic [7:0] host_rdata;

   modport master (
      output host_req, host_we, host_addr, host_wdata,
      input  host_gnt, host_rvalid, host_rdata
   );

   modport slave (
      input  host_req, host_we, host_addr, host_wdata,
      output host_gnt, host_rvalid, host_rdata
   );

endinterface

// File: rtl/core_run_ctrl_dmem_port_mux.sv
// ---------------------------------------------------------------------------
// dmem_port_mux
// Selects who drives the single dat_mem port and registers host read data.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   i_hostOwns      : host may use the port this cycle (IDLE/DONE)
//   i_coreOwns      : core drives the port this cycle (RUN)
//   hostBus         : host port (slave modport)
//   core_wr_en/addr/wdata : core store request
//   mem_wr_en/addr/wdata  : to dat_mem
//   mem_rdata       : from dat_mem, combinational read
// ---------------------------------------------------------------------------
module dmem_port_mux (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_hostOwns,
   input  logic                  i_coreOwns,
   core_run_ctrl_if.slave        hostBus,
   input  logic                  core_wr_en,
   input  logic [7:0]            core_addr,
   input  logic [7:0]            core_wdata,
   output logic                  mem_wr_en,
   output logic [7:0]            mem_addr,
   output logic [7:0]            mem_wdata,
   input  logic [7:0]            mem_rdata
);

   logic       w_hostGnt;
   logic       w_hostRead;
   logic       r_rvalid;
   logic [7:0] r_rdata;

   // Grant is purely combinational so a host write commits on the same edge.
   assign w_hostGnt  = i_hostOwns & hostBus.host_req;
   assign w_hostRead = w_hostGnt & ~hostBus.host_we;

   assign hostBus.host_gnt    = w_hostGnt;
   assign hostBus.host_rvalid = r_rvalid;
   assign hostBus.host_rdata  = r_rdata;

   // Port select: core in RUN, host when granted, otherwise the port is
   // parked at all zeros so dat_mem sees no stray writes.
   always_comb begin
      mem_wr_en = 1'b0;
      mem_addr  = 8'h00;
      mem_wdata = 8'h00;
      if (i_coreOwns) begin
         mem_wr_en = core_wr_en;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end else if (w_hostGnt) begin
         mem_wr_en = hostBus.host_we;
         mem_addr  = hostBus.host_addr;
         mem_wdata = hostBus.host_wdata;
      end
   end

   // Read data is captured at the grant edge and valid for exactly one
   // cycle; reset discards a read that is still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid <= 1'b0;
         r_rdata  <= 8'h00;
      end else begin
         r_rvalid <= w_hostRead;
         if (w_hostRead) begin
            r_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: rtl/core_run_ctrl.sv
// ---------------------------------------------------------------------------
// core_run_ctrl
// Run controller and data-memory port arbiter for the single-cycle core.
// Sequences IDLE -> LAUNCH -> RUN -> DONE, counts run cycles and shares the
// dat_mem port between the core (RUN) and the host (IDLE/DONE).
// Build option: define RUN_CTRL_WATCHDOG_EN to enable the MAX_CYC watchdog;
// without it timeout stays 0 and RUN ends only at END_PC.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start             : run request, level or pulse
//   prog_ctr          : current PC value (D bits)
//   core_wr_en/addr/wdata : core store request
//   hostBus           : host loader/readback port (slave modport)
//   mem_wr_en/addr/wdata, mem_rdata : dat_mem port
//   pc_load           : forces next PC to the start address (LAUNCH)
//   core_en           : gates PC advance, RegWrite and stores (RUN)
//   busy              : LAUNCH or RUN
//   done              : held high in DONE
//   timeout           : watchdog ended the last run
//   cycle_count       : run cycles of the current/last run (CYC_W bits)
// ---------------------------------------------------------------------------
module core_run_ctrl
   import core_pkg::*;
#(
   parameter int D       = 12,
   parameter int END_PC  = END_PC_DEFAULT,
   parameter int CYC_W   = CYC_W_DEFAULT,
   parameter int MAX_CYC = 2**CYC_W - 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [D-1:0]     prog_ctr,
   input  logic             core_wr_en,
   input  logic [7:0]       core_addr,
   input  logic [7:0]       core_wdata,
   core_run_ctrl_if.slave   hostBus,
   output logic             mem_wr_en,
   output logic [7:0]       mem_addr,
   output logic [7:0]       mem_wdata,
   input  logic [7:0]       mem_rdata,
   output logic             pc_load,
   output logic             core_en,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CYC_W-1:0] cycle_count
);

`ifdef RUN_CTRL_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   localparam logic [D-1:0]     END_PC_VAL = D'(END_PC);
   localparam logic [CYC_W-1:0] WD_LIMIT   = CYC_W'(MAX_CYC - 1);

   run_state_t       r_state;
   logic             r_startPend;
   logic             r_pcLoad;
   logic             r_coreEn;
   logic             r_busy;
   logic             r_done;
   logic             r_timeout;
   logic [CYC_W-1:0] r_count;

   logic             w_endHit;
   logic             w_wdHit;
   logic             w_hostOwns;
   logic             w_coreOwns;

   assign w_endHit   = (prog_ctr == END_PC_VAL);
   assign w_wdHit    = WD_EN && (r_count == WD_LIMIT);
   assign w_hostOwns = (r_state == IDLE) || (r_state == DONE);
   assign w_coreOwns = (r_state == RUN);

   // Run sequencer. Every control output is a register updated together
   // with the state, so start never reaches an output combinationally and
   // reset drops core_en at once. A start that collides with a host access
   // is remembered in r_startPend and launched once the host lets go.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_startPend <= 1'b0;
         r_pcLoad    <= 1'b0;
         r_coreEn    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_count     <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if ((start || r_startPend) && !hostBus.host_req) begin
                  r_state  <= LAUNCH;
                  r_pcLoad <= 1'b1;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
               end else if (start) begin
                  r_startPend <= 1'b1;
               end
            end
            LAUNCH: begin
               r_state     <= RUN;
               r_pcLoad    <= 1'b0;
               r_coreEn    <= 1'b1;
               r_count     <= '0;
               r_timeout   <= 1'b0;
               r_startPend <= 1'b0;
            end
            RUN: begin
               if (r_count != '1) begin
                  r_count <= r_count + 1'b1;
               end
               // Normal completion takes priority over the watchdog.
               if (w_endHit || w_wdHit) begin
                  r_state   <= DONE;
                  r_coreEn  <= 1'b0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_timeout <= !w_endHit;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign pc_load     = r_pcLoad;
   assign core_en     = r_coreEn;
   assign busy        = r_busy;
   assign done        = r_done;
   assign timeout     = r_timeout;
   assign cycle_count = r_count;

   dmem_port_mux uPortMux (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_hostOwns (w_hostOwns),
      .i_coreOwns (w_coreOwns),
      .hostBus    (hostBus),
      .core_wr_en (core_wr_en),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .mem_wr_en  (mem_wr_en),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

endmodule

// File: tb/tb_core_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_run_ctrl
// Directed bench for core_run_ctrl with a small behavioural dat_mem.
// The DUT is built with CYC_W=6 (saturation at 63) and MAX_CYC=20 so both
// the watchdog and the saturation behaviour are reachable quickly.
// Build option: RUN_CTRL_WATCHDOG_EN selects the watchdog expectations.
// ---------------------------------------------------------------------------
module tb_core_run_ctrl;

   localparam int D       = 12;
   localparam int CYC_W   = 6;
   localparam int MAX_CYC = 20;

`ifdef RUN_CTRL_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [D-1:0]     prog_ctr;
   logic             core_wr_en;
   logic [7:0]       core_addr;
   logic [7:0]       core_wdata;
   logic             mem_wr_en;
   logic [7:0]       mem_addr;
   logic [7:0]       mem_wdata;
   logic [7:0]       mem_rdata;
   logic             pc_load;
   logic             core_en;
   logic             busy;
   logic             done;
   logic             timeout;
   logic [CYC_W-1:0] cycle_count;

   int total;
   int bad;

   logic [7:0] memArr [256];

   core_run_ctrl_if hostBus ();

   core_run_ctrl #(
      .D       (D),
      .END_PC  (128),
      .CYC_W   (CYC_W),
      .MAX_CYC (MAX_CYC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .prog_ctr    (prog_ctr),
      .core_wr_en  (core_wr_en),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .hostBus     (hostBus),
      .mem_wr_en   (mem_wr_en),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .pc_load     (pc_load),
      .core_en     (core_en),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout),
      .cycle_count (cycle_count)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural dat_mem: combinational read, write on the rising edge
   always @(posedge clk) begin
      if (mem_wr_en) begin
         memArr[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = memArr[mem_addr];

   // Hard time limit so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL time_limit: simulation still running, required finish");
      $fatal(1, "[TB] time limit");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: inputs take effect at the rising edge, outputs are then
   // observed at the following falling edge.
   task automatic applyStimulus(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic setHost(input logic req, input logic we,
                          input logic [7:0] addr, input logic [7:0] wdata);
      hostBus.host_req   = req;
      hostBus.host_we    = we;
      hostBus.host_addr  = addr;
      hostBus.host_wdata = wdata;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      start      = 1'b0;
      prog_ctr   = '0;
      core_wr_en = 1'b0;
      core_addr  = 8'h00;
      core_wdata = 8'h00;
      setHost(1'b0, 1'b0, 8'h00, 8'h00);

      // ---------------- reset state ----------------
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_busy",    32'(busy),        32'd0);
      checkOutput("rst_done",    32'(done),        32'd0);
      checkOutput("rst_core_en", 32'(core_en),     32'd0);
      checkOutput("rst_pc_load", 32'(pc_load),     32'd0);
      checkOutput("rst_count",   32'(cycle_count), 32'd0);
      checkOutput("rst_rvalid",  32'(hostBus.host_rvalid), 32'd0);
      checkOutput("rst_mem_addr", 32'(mem_addr),   32'd0);
      rst_n = 1'b1;
      applyStimulus(1);

      // ---------------- host write then read in IDLE ----------------
      setHost(1'b1, 1'b1, 8'h10, 8'h5A);
      #1;
      checkOutput("hw_gnt",      32'(hostBus.host_gnt), 32'd1);
      checkOutput("hw_mem_we",   32'(mem_wr_en),   32'd1);
      checkOutput("hw_mem_addr", 32'(mem_addr),    32'h10);
      checkOutput("hw_mem_wd",   32'(mem_wdata),   32'h5A);
      applyStimulus(1);
      setHost(1'b1, 1'b0, 8'h10, 8'h00);
      #1;
      checkOutput("hr_gnt",      32'(hostBus.host_gnt), 32'd1);
      checkOutput("hr_mem_we",   32'(mem_wr_en),   32'd0);
      checkOutput("hr_rvalid0",  32'(hostBus.host_rvalid), 32'd0);
      applyStimulus(1);
      setHost(1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      checkOutput("hr_rvalid1",  32'(hostBus.host_rvalid), 32'd1);
      checkOutput("hr_rdata",    32'(hostBus.host_rdata),  32'h5A);
      checkOutput("idle_gnt0",   32'(hostBus.host_gnt),    32'd0);
      checkOutput("idle_addr0",  32'(mem_addr),    32'd0);
      applyStimulus(1);
      checkOutput("hr_rvalid2",  32'(hostBus.host_rvalid), 32'd0);

      // ---------------- start pulse, run to END_PC ----------------
      start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      checkOutput("l_pc_load",   32'(pc_load),     32'd1);
      checkOutput("l_busy",      32'(busy),        32'd1);
      checkOutput("l_core_en",   32'(core_en),     32'd0);
      applyStimulus(1);
      // first RUN cycle; host requests while the core stores
      checkOutput("r_core_en",   32'(core_en),     32'd1);
      checkOutput("r_pc_load",   32'(pc_load),     32'd0);
      checkOutput("r_count0",    32'(cycle_count), 32'd0);
      core_wr_en = 1'b1;
      core_addr  = 8'h33;
      core_wdata = 8'h77;
      setHost(1'b1, 1'b0, 8'h10, 8'h00);
      #1;
      checkOutput("r_host_gnt",  32'(hostBus.host_gnt), 32'd0);
      checkOutput("r_mem_we",    32'(mem_wr_en),   32'd1);
      checkOutput("r_mem_addr",  32'(mem_addr),    32'h33);
      checkOutput("r_mem_wd",    32'(mem_wdata),   32'h77);
      applyStimulus(1);
      core_wr_en = 1'b0;
      applyStimulus(38);
      // 40th RUN cycle in the plain build
      prog_ctr = 12'd128;
      applyStimulus(1);
      prog_ctr = '0;
      checkOutput("d_done",      32'(done),        32'd1);
      checkOutput("d_core_en",   32'(core_en),     32'd0);
      checkOutput("d_busy",      32'(busy),        32'd0);
      checkOutput("d_timeout",   32'(timeout),     WD ? 32'd1 : 32'd0);
      checkOutput("d_count",     32'(cycle_count), WD ? 32'd20 : 32'd40);
      checkOutput("d_host_gnt",  32'(hostBus.host_gnt), 32'd1);
      checkOutput("d_mem_addr",  32'(mem_addr),    32'h10);
      applyStimulus(1);
      checkOutput("d_rvalid",    32'(hostBus.host_rvalid), 32'd1);
      checkOutput("d_rdata",     32'(hostBus.host_rdata),  32'h5A);
      checkOutput("d_count_frz", 32'(cycle_count), WD ? 32'd20 : 32'd40);

      // ---------------- start held with host_req for 3 cycles ----------------
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput($sformatf("c_gnt%0d", i), 32'(hostBus.host_gnt), 32'd1);
         applyStimulus(1);
      end
      checkOutput("c_still_done", 32'(done),       32'd1);
      checkOutput("c_not_busy",  32'(busy),        32'd0);
      start = 1'b0;
      setHost(1'b0, 1'b0, 8'h00, 8'h00);
      applyStimulus(1);
      checkOutput("c_launch",    32'(pc_load),     32'd1);
      checkOutput("c_done_clr",  32'(done),        32'd0);
      checkOutput("c_core_en0",  32'(core_en),     32'd0);
      applyStimulus(1);
      checkOutput("c_core_en1",  32'(core_en),     32'd1);
      checkOutput("c_count0",    32'(cycle_count), 32'd0);
      checkOutput("c_timeout0",  32'(timeout),     32'd0);

      // ---------------- watchdog / saturation ----------------
      applyStimulus(19);
      checkOutput("w_count19",   32'(cycle_count), 32'd19);
      checkOutput("w_busy19",    32'(busy),        32'd1);
      applyStimulus(1);
      checkOutput("w_done",      32'(done),        WD ? 32'd1 : 32'd0);
      checkOutput("w_timeout",   32'(timeout),     WD ? 32'd1 : 32'd0);
      checkOutput("w_count20",   32'(cycle_count), 32'd20);
      applyStimulus(50);
      checkOutput("w_count_sat", 32'(cycle_count), WD ? 32'd20 : 32'd63);
      checkOutput("w_busy_sat",  32'(busy),        WD ? 32'd0 : 32'd1);

      // ---------------- asynchronous reset mid-run ----------------
      start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      applyStimulus(2);
      checkOutput("x_core_en1",  32'(core_en),     32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("x_core_en0",  32'(core_en),     32'd0);
      checkOutput("x_busy0",     32'(busy),        32'd0);
      checkOutput("x_count0",    32'(cycle_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      checkOutput("x_launch",    32'(pc_load),     32'd1);
      applyStimulus(1);
      checkOutput("x_run",       32'(core_en),     32'd1);
      prog_ctr = 12'd128;
      applyStimulus(1);
      prog_ctr = '0;
      checkOutput("x_done",      32'(done),        32'd1);
      checkOutput("x_count1",    32'(cycle_count), 32'd1);
      checkOutput("x_timeout",   32'(timeout),     32'd0);

`ifdef RUN_CTRL_WATCHDOG_EN
      // ---------------- END_PC and watchdog in the same cycle ----------------
      start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      applyStimulus(1);
      applyStimulus(19);
      prog_ctr = 12'd128;
      applyStimulus(1);
      prog_ctr = '0;
      checkOutput("t_done",      32'(done),        32'd1);
      checkOutput("t_timeout",   32'(timeout),     32'd0);
      checkOutput("t_count",     32'(cycle_count), 32'd20);
`endif

      // ---------------- reset kills an in-flight host read ----------------
      setHost(1'b1, 1'b0, 8'h10, 8'h00);
      #1;
      checkOutput("f_gnt",       32'(hostBus.host_gnt), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("f_rvalid0",   32'(hostBus.host_rvalid), 32'd0);
      setHost(1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1);
      checkOutput("f_idle_done", 32'(done),        32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
